// File: rtl/prim_ram_2p_sync.sv
// Single-clock two-port RAM with per-lane write masks, selectable read-during-write and optional output register.
// Optional per-lane even parity storage and checking is enabled by defining PRIM_RAM_2P_PARITY_EN.
module prim_ram_2p_sync #(
    parameter int Width           = 32,
    parameter int Depth           = 1024,
    parameter int DataBitsPerMask = 8,
    parameter int OutputReg       = 0,
    parameter int RdwMode         = 0,
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int MW = Width / DataBitsPerMask
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_req_i,
    input  logic             a_write_i,
    input  logic [AW-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [MW-1:0]    a_wmask_i,
    output logic             a_rvalid_o,
    output logic [Width-1:0] a_rdata_o,
    output logic [1:0]       a_rerror_o,
    input  logic             b_req_i,
    input  logic             b_write_i,
    input  logic [AW-1:0]    b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    input  logic [MW-1:0]    b_wmask_i,
    output logic             b_rvalid_o,
    output logic [Width-1:0] b_rdata_o,
    output logic [1:0]       b_rerror_o,
    output logic             b_collision_o
);

    if (Width % DataBitsPerMask != 0) begin : g_bad_mask
        $error("Width must be a multiple of DataBitsPerMask");
    end
    if (Depth < 2) begin : g_bad_depth
        $error("Depth must be at least 2");
    end

    function automatic logic [Width-1:0] lane_bits(input logic [MW-1:0] m);
        logic [Width-1:0] b;
        b = {Width{1'b0}};
        for (int k = 0; k < MW; k++) b[k*DataBitsPerMask +: DataBitsPerMask] = {DataBitsPerMask{m[k]}};
        return b;
    endfunction

    logic [Width-1:0] mem_r [Depth];

    logic             a_in_range_s, b_in_range_s;
    logic             a_we_s, b_we_raw_s, b_we_s, collision_s;
    logic             a_fwd_s, b_fwd_s, a_perr_s, b_perr_s;
    logic [Width-1:0] a_old_s, b_old_s, a_merged_s, b_merged_s, a_rd_s, b_rd_s;

    assign a_in_range_s = (32'(a_addr_i) < 32'(Depth));
    assign b_in_range_s = (32'(b_addr_i) < 32'(Depth));
    assign a_old_s      = a_in_range_s ? mem_r[a_addr_i] : {Width{1'b0}};
    assign b_old_s      = b_in_range_s ? mem_r[b_addr_i] : {Width{1'b0}};

    // An all-zero mask or an out-of-range address turns a write into a plain read
    assign a_we_s      = a_req_i & a_write_i & (|a_wmask_i) & a_in_range_s;
    assign b_we_raw_s  = b_req_i & b_write_i & (|b_wmask_i) & b_in_range_s;
    assign collision_s = a_we_s & b_we_raw_s & (a_addr_i == b_addr_i);
    assign b_we_s      = b_we_raw_s & ~collision_s;

    assign a_merged_s = (a_old_s & ~lane_bits(a_wmask_i)) | (a_wdata_i & lane_bits(a_wmask_i));
    assign b_merged_s = (b_old_s & ~lane_bits(b_wmask_i)) | (b_wdata_i & lane_bits(b_wmask_i));
    assign a_fwd_s    = (RdwMode != 0) & a_we_s;
    assign b_fwd_s    = (RdwMode != 0) & b_we_s;
    assign a_rd_s     = a_fwd_s ? a_merged_s : a_old_s;
    assign b_rd_s     = b_fwd_s ? b_merged_s : b_old_s;

`ifdef PRIM_RAM_2P_PARITY_EN
    logic [MW-1:0] par_mem_r [Depth];
    logic [MW-1:0] a_par_old_s, b_par_old_s;

    function automatic logic [MW-1:0] lane_parity(input logic [Width-1:0] d);
        logic [MW-1:0] p;
        p = {MW{1'b0}};
        for (int k = 0; k < MW; k++) p[k] = ^d[k*DataBitsPerMask +: DataBitsPerMask];
        return p;
    endfunction

    assign a_par_old_s = a_in_range_s ? par_mem_r[a_addr_i] : {MW{1'b0}};
    assign b_par_old_s = b_in_range_s ? par_mem_r[b_addr_i] : {MW{1'b0}};
    // Forwarded write-first data is freshly generated, so it is never flagged
    assign a_perr_s = ~a_fwd_s & (|(lane_parity(a_old_s) ^ a_par_old_s));
    assign b_perr_s = ~b_fwd_s & (|(lane_parity(b_old_s) ^ b_par_old_s));

    // Parity lanes are written together with their data lanes
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < MW; k++) begin
                if (a_we_s && a_wmask_i[k]) par_mem_r[a_addr_i][k] <= ^a_wdata_i[k*DataBitsPerMask +: DataBitsPerMask];
                if (b_we_s && b_wmask_i[k]) par_mem_r[b_addr_i][k] <= ^b_wdata_i[k*DataBitsPerMask +: DataBitsPerMask];
            end
        end
    end
`else
    assign a_perr_s = 1'b0;
    assign b_perr_s = 1'b0;
`endif

    // Masked lane writes; the array itself is never reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < MW; k++) begin
                if (a_we_s && a_wmask_i[k])
                    mem_r[a_addr_i][k*DataBitsPerMask +: DataBitsPerMask] <= a_wdata_i[k*DataBitsPerMask +: DataBitsPerMask];
                if (b_we_s && b_wmask_i[k])
                    mem_r[b_addr_i][k*DataBitsPerMask +: DataBitsPerMask] <= b_wdata_i[k*DataBitsPerMask +: DataBitsPerMask];
            end
        end
    end

    logic             a_v1_r, b_v1_r;
    logic [Width-1:0] a_d1_r, b_d1_r;
    logic [1:0]       a_e1_r, b_e1_r;

    // First read stage; data and error hold whenever no request was made
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_v1_r        <= 1'b0;
            b_v1_r        <= 1'b0;
            a_d1_r        <= {Width{1'b0}};
            b_d1_r        <= {Width{1'b0}};
            a_e1_r        <= 2'b00;
            b_e1_r        <= 2'b00;
            b_collision_o <= 1'b0;
        end else begin
            a_v1_r        <= a_req_i;
            b_v1_r        <= b_req_i;
            b_collision_o <= collision_s;
            if (a_req_i) begin
                a_d1_r <= a_rd_s;
                a_e1_r <= {a_perr_s, ~a_in_range_s};
            end
            if (b_req_i) begin
                b_d1_r <= b_rd_s;
                b_e1_r <= {b_perr_s, ~b_in_range_s};
            end
        end
    end

    if (OutputReg != 0) begin : g_oreg
        logic             a_v2_r, b_v2_r;
        logic [Width-1:0] a_d2_r, b_d2_r;
        logic [1:0]       a_e2_r, b_e2_r;

        // Optional second stage for timing
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                a_v2_r <= 1'b0;
                b_v2_r <= 1'b0;
                a_d2_r <= {Width{1'b0}};
                b_d2_r <= {Width{1'b0}};
                a_e2_r <= 2'b00;
                b_e2_r <= 2'b00;
            end else begin
                a_v2_r <= a_v1_r;
                b_v2_r <= b_v1_r;
                if (a_v1_r) begin
                    a_d2_r <= a_d1_r;
                    a_e2_r <= a_e1_r;
                end
                if (b_v1_r) begin
                    b_d2_r <= b_d1_r;
                    b_e2_r <= b_e1_r;
                end
            end
        end

        assign a_rvalid_o = a_v2_r;
        assign a_rdata_o  = a_d2_r;
        assign a_rerror_o = a_e2_r;
        assign b_rvalid_o = b_v2_r;
        assign b_rdata_o  = b_d2_r;
        assign b_rerror_o = b_e2_r;
    end else begin : g_noreg
        assign a_rvalid_o = a_v1_r;
        assign a_rdata_o  = a_d1_r;
        assign a_rerror_o = a_e1_r;
        assign b_rvalid_o = b_v1_r;
        assign b_rdata_o  = b_d1_r;
        assign b_rerror_o = b_e1_r;
    end

endmodule

// File: tb/tb_prim_ram_2p_sync.sv
// Bench for prim_ram_2p_sync: a read-first/latency-1 instance and a write-first/latency-2 instance share stimulus.
// Parity scenarios are included when PRIM_RAM_2P_PARITY_EN is defined.
module tb_prim_ram_2p_sync;
    localparam int D = 1000;
`ifdef PRIM_RAM_2P_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req, a_write, b_req, b_write;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_wmask, b_wmask;

    logic        a_rv0, b_rv0, a_rv1, b_rv1, coll0, coll1;
    logic [31:0] a_rd0, b_rd0, a_rd1, b_rd1;
    logic [1:0]  a_re0, b_re0, a_re1, b_re1;

    prim_ram_2p_sync #(.Width(32), .Depth(D), .DataBitsPerMask(8), .OutputReg(0), .RdwMode(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_wmask_i(a_wmask),
        .a_rvalid_o(a_rv0), .a_rdata_o(a_rd0), .a_rerror_o(a_re0),
        .b_req_i(b_req), .b_write_i(b_write), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_wmask_i(b_wmask),
        .b_rvalid_o(b_rv0), .b_rdata_o(b_rd0), .b_rerror_o(b_re0), .b_collision_o(coll0));

    prim_ram_2p_sync #(.Width(32), .Depth(D), .DataBitsPerMask(8), .OutputReg(1), .RdwMode(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_wmask_i(a_wmask),
        .a_rvalid_o(a_rv1), .a_rdata_o(a_rd1), .a_rerror_o(a_re1),
        .b_req_i(b_req), .b_write_i(b_write), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_wmask_i(b_wmask),
        .b_rvalid_o(b_rv1), .b_rdata_o(b_rd1), .b_rerror_o(b_re1), .b_collision_o(coll1));

    // Outputs indexed as [instance][port]
    logic        ov [2][2];
    logic [31:0] od [2][2];
    logic [1:0]  oe [2][2];
    assign ov[0][0] = a_rv0; assign od[0][0] = a_rd0; assign oe[0][0] = a_re0;
    assign ov[0][1] = b_rv0; assign od[0][1] = b_rd0; assign oe[0][1] = b_re0;
    assign ov[1][0] = a_rv1; assign od[1][0] = a_rd1; assign oe[1][0] = a_re1;
    assign ov[1][1] = b_rv1; assign od[1][1] = b_rd1; assign oe[1][1] = b_re1;

    // Reference model: word contents, lanes with corrupted parity, expected visible outputs
    logic [31:0] mdl [1024];
    logic [3:0]  bad [1024];
    logic        ev [2][2];
    logic [31:0] ed [2][2];
    logic [1:0]  ee [2][2];
    logic        ec;
    logic        dv [2];
    logic [31:0] dd [2];
    logic [1:0]  de [2];

    int total = 0;
    int nbad  = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                ev[d][p] = 1'b0; ed[d][p] = 32'h0; ee[d][p] = 2'b00;
            end
        for (int p = 0; p < 2; p++) begin
            dv[p] = 1'b0; dd[p] = 32'h0; de[p] = 2'b00;
        end
        ec = 1'b0;
    endtask

    // One clock of stimulus; the model predicts what each instance shows afterwards
    task automatic step(input logic ar, input logic aw, input logic [9:0] aa, input logic [31:0] ad, input logic [3:0] am,
                        input logic br, input logic bw, input logic [9:0] ba, input logic [31:0] bd, input logic [3:0] bm);
        logic rq [2]; logic wr [2]; logic [9:0] ad_ [2]; logic [31:0] wd [2]; logic [3:0] mk [2];
        logic [31:0] lm, old [2], mrg [2];
        logic inr [2], we [2], pe [2], coll;
        logic c0v [2], c1v [2];
        logic [31:0] c0d [2], c1d [2];
        logic [1:0] c0e [2], c1e [2];
        a_req = ar; a_write = aw; a_addr = aa; a_wdata = ad; a_wmask = am;
        b_req = br; b_write = bw; b_addr = ba; b_wdata = bd; b_wmask = bm;
        rq[0] = ar; wr[0] = aw; ad_[0] = aa; wd[0] = ad; mk[0] = am;
        rq[1] = br; wr[1] = bw; ad_[1] = ba; wd[1] = bd; mk[1] = bm;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) lm[k*8 +: 8] = {8{mk[p][k]}};
            inr[p] = (int'(ad_[p]) < D);
            we[p]  = rq[p] && wr[p] && (mk[p] != 4'h0) && inr[p];
            old[p] = inr[p] ? mdl[ad_[p]] : 32'h0;
            mrg[p] = (old[p] & ~lm) | (wd[p] & lm);
            pe[p]  = PAR && inr[p] && (bad[ad_[p]] != 4'h0);
        end
        coll = we[0] && we[1] && (ad_[0] == ad_[1]);
        if (coll) we[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            c0v[p] = rq[p]; c0d[p] = old[p]; c0e[p] = {pe[p], !inr[p]};
            c1v[p] = rq[p];
            c1d[p] = we[p] ? mrg[p] : old[p];
            c1e[p] = we[p] ? 2'b00 : c0e[p];
        end
        for (int p = 0; p < 2; p++)
            if (we[p]) begin
                mdl[ad_[p]] = mrg[p];
                bad[ad_[p]] = bad[ad_[p]] & ~mk[p];
            end
        @(posedge clk);
        #1;
        ec = coll;
        for (int p = 0; p < 2; p++) begin
            ev[0][p] = c0v[p];
            if (c0v[p]) begin ed[0][p] = c0d[p]; ee[0][p] = c0e[p]; end
            ev[1][p] = dv[p];
            if (dv[p]) begin ed[1][p] = dd[p]; ee[1][p] = de[p]; end
            dv[p] = c1v[p]; dd[p] = c1d[p]; de[p] = c1e[p];
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req = 1'b0; a_write = 1'b0; a_addr = 10'd0; a_wdata = 32'h0; a_wmask = 4'h0;
        b_req = 1'b0; b_write = 1'b0; b_addr = 10'd0; b_wdata = 32'h0; b_wmask = 4'h0;
        for (int i = 0; i < 1024; i++) begin mdl[i] = 32'h0; bad[i] = 4'h0; end
        model_reset();
        #1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                total++;
                if (ov[d][p] !== 1'b0 || od[d][p] !== 32'h0 || oe[d][p] !== 2'b00) begin
                    nbad++;
                    $display("FAIL reset_out inst%0d port%0d: got v=%b d=%h e=%b, want 0", d, p, ov[d][p], od[d][p], oe[d][p]);
                end
            end
        total++;
        if (coll0 !== 1'b0 || coll1 !== 1'b0) begin
            nbad++;
            $display("FAIL reset_coll: got %b/%b, want 0", coll0, coll1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_init();
        for (int i = 0; i < D / 2; i++)
            step(1'b1, 1'b1, 10'(i), $urandom, 4'hF, 1'b1, 1'b1, 10'(i + D / 2), $urandom, 4'hF);
        step(1'b1, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 1'b0, 10'd1, 32'h0, 4'h0);
        step(1'b1, 1'b0, 10'd2, 32'h0, 4'h0, 1'b1, 1'b0, 10'd3, 32'h0, 4'h0);
        total++;
        if (coll0 !== 1'b0) begin
            nbad++;
            $display("FAIL init_coll: got %b, want 0", coll0);
        end
    endtask

    task automatic test_basic();
        step(1'b1, 1'b1, 10'd5, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        idle();
        step(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        total++;
        if (a_rv0 !== 1'b1 || a_rd0 !== 32'hA5A5A5A5 || a_rv1 !== 1'b0) begin
            nbad++;
            $display("FAIL basic_lat1: got v0=%b d0=%h v1=%b, want 1 a5a5a5a5 0", a_rv0, a_rd0, a_rv1);
        end
        idle();
        total++;
        if (a_rv0 !== 1'b0 || a_rd0 !== 32'hA5A5A5A5 || a_rv1 !== 1'b1 || a_rd1 !== 32'hA5A5A5A5) begin
            nbad++;
            $display("FAIL basic_lat2: got v0=%b d0=%h v1=%b d1=%h, want 0 a5a5a5a5 1 a5a5a5a5", a_rv0, a_rd0, a_rv1, a_rd1);
        end
    endtask

    task automatic test_mask();
        step(1'b1, 1'b1, 10'd7, 32'h11223344, 4'hF, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        step(1'b1, 1'b1, 10'd7, 32'hFFFFFFFF, 4'b0101, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        total++;
        if (a_rd0 !== 32'h11223344) begin
            nbad++;
            $display("FAIL mask_readfirst: got %h, want 11223344", a_rd0);
        end
        step(1'b1, 1'b0, 10'd7, 32'h0, 4'h0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        total++;
        if (a_rd0 !== 32'h11FF33FF || a_rd1 !== 32'h11FF33FF) begin
            nbad++;
            $display("FAIL mask_merge: got %h/%h, want 11ff33ff", a_rd0, a_rd1);
        end
    endtask

    task automatic test_rdw();
        step(1'b1, 1'b1, 10'd9, 32'h0, 4'hF, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        step(1'b1, 1'b1, 10'd9, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        total++;
        if (a_rd0 !== 32'h0) begin
            nbad++;
            $display("FAIL rdw_old: got %h, want 00000000", a_rd0);
        end
        idle();
        total++;
        if (a_rd1 !== 32'hDEADBEEF || a_rv1 !== 1'b1) begin
            nbad++;
            $display("FAIL rdw_new: got v=%b d=%h, want 1 deadbeef", a_rv1, a_rd1);
        end
    endtask

    task automatic test_collision();
        step(1'b1, 1'b1, 10'd3, 32'h33, 4'hF, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        step(1'b1, 1'b1, 10'd3, 32'h1, 4'hF, 1'b1, 1'b1, 10'd3, 32'h2, 4'hF);
        total++;
        if (coll0 !== 1'b1 || coll1 !== 1'b1 || b_rd0 !== 32'h33) begin
            nbad++;
            $display("FAIL coll_pulse: got c=%b/%b bd=%h, want 1/1 00000033", coll0, coll1, b_rd0);
        end
        idle();
        total++;
        if (coll0 !== 1'b0 || coll1 !== 1'b0 || b_rv1 !== 1'b1 || b_rd1 !== 32'h33) begin
            nbad++;
            $display("FAIL coll_once: got c=%b/%b bv1=%b bd1=%h, want 0/0 1 00000033", coll0, coll1, b_rv1, b_rd1);
        end
        step(1'b1, 1'b0, 10'd3, 32'h0, 4'h0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        total++;
        if (a_rd0 !== 32'h1) begin
            nbad++;
            $display("FAIL coll_winner: got %h, want 00000001", a_rd0);
        end
        step(1'b1, 1'b1, 10'd3, 32'h44, 4'hF, 1'b1, 1'b0, 10'd3, 32'h0, 4'h0);
        total++;
        if (b_rd0 !== 32'h1 || coll0 !== 1'b0) begin
            nbad++;
            $display("FAIL cross_rdw: got bd=%h c=%b, want 00000001 0", b_rd0, coll0);
        end
        step(1'b1, 1'b0, 10'd3, 32'h0, 4'h0, 1'b1, 1'b0, 10'd3, 32'h0, 4'h0);
        total++;
        if (b_rd1 !== 32'h1 || a_rd1 !== 32'h44) begin
            nbad++;
            $display("FAIL cross_rdw2: got bd=%h ad=%h, want 00000001 00000044", b_rd1, a_rd1);
        end
        total++;
        if (a_rd0 !== 32'h44 || b_rd0 !== 32'h44) begin
            nbad++;
            $display("FAIL both_read: got %h/%h, want 00000044", a_rd0, b_rd0);
        end
    endtask

    task automatic test_out_of_range();
        step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 1'b0, 10'd1010, 32'h0, 4'h0);
        total++;
        if (b_rv0 !== 1'b1 || b_rd0 !== 32'h0 || b_re0 !== 2'b01) begin
            nbad++;
            $display("FAIL oor_read: got v=%b d=%h e=%b, want 1 00000000 01", b_rv0, b_rd0, b_re0);
        end
        step(1'b1, 1'b1, 10'd1010, 32'h5, 4'hF, 1'b1, 1'b1, 10'd1010, 32'h6, 4'hF);
        total++;
        if (coll0 !== 1'b0 || a_re0 !== 2'b01 || b_re0 !== 2'b01) begin
            nbad++;
            $display("FAIL oor_write: got c=%b ae=%b be=%b, want 0 01 01", coll0, a_re0, b_re0);
        end
        step(1'b1, 1'b0, 10'd999, 32'h0, 4'h0, 1'b1, 1'b0, 10'd1010, 32'h0, 4'h0);
        total++;
        if (b_rd1 !== 32'h0 || b_re1 !== 2'b01 || a_re0 !== 2'b00 || a_rd0 !== mdl[999]) begin
            nbad++;
            $display("FAIL oor_noeffect: got bd1=%h be1=%b ae=%b ad=%h, want 0 01 00 %h", b_rd1, b_re1, a_re0, a_rd0, mdl[999]);
        end
    endtask

    task automatic test_random();
        logic [9:0] aa, ba;
        for (int n = 0; n < 400; n++) begin
            aa = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(995, 1023)) : 10'($urandom_range(10, 13));
            ba = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(995, 1023)) : 10'($urandom_range(10, 13));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), aa, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ba, $urandom, 4'($urandom_range(0, 15)));
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    total++;
                    if (ov[d][p] !== ev[d][p] || od[d][p] !== ed[d][p] || oe[d][p] !== ee[d][p]) begin
                        nbad++;
                        $display("FAIL rand inst%0d port%0d cyc%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                                 d, p, n, ov[d][p], od[d][p], oe[d][p], ev[d][p], ed[d][p], ee[d][p]);
                    end
                end
            total++;
            if (coll0 !== ec || coll1 !== ec) begin
                nbad++;
                $display("FAIL rand_coll cyc%0d: got %b/%b, want %b", n, coll0, coll1, ec);
            end
        end
    endtask

`ifdef PRIM_RAM_2P_PARITY_EN
    task automatic test_parity();
        step(1'b1, 1'b1, 10'd4, 32'h0, 4'hF, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        idle();
        idle();
        dut0.par_mem_r[4][0] = ~dut0.par_mem_r[4][0];
        dut1.par_mem_r[4][0] = ~dut1.par_mem_r[4][0];
        bad[4] = 4'b0001;
        step(1'b1, 1'b0, 10'd4, 32'h0, 4'h0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        total++;
        if (a_re0 !== 2'b10) begin
            nbad++;
            $display("FAIL parity_err: got %b, want 10", a_re0);
        end
        step(1'b1, 1'b1, 10'd4, 32'h0, 4'hF, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        total++;
        if (a_re1 !== 2'b10 || a_re0 !== 2'b10) begin
            nbad++;
            $display("FAIL parity_err2: got %b/%b, want 10/10", a_re0, a_re1);
        end
        idle();
        total++;
        if (a_re1 !== 2'b00) begin
            nbad++;
            $display("FAIL parity_fwd: got %b, want 00", a_re1);
        end
    endtask
`endif

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        rst = 1'b1;
        #1;
        total++;
        if (a_rv0 !== 1'b0 || a_rv1 !== 1'b0 || a_rd1 !== 32'h0 || a_rd0 !== 32'h0) begin
            nbad++;
            $display("FAIL rst_mid: got v=%b/%b d=%h/%h, want 0", a_rv0, a_rv1, a_rd0, a_rd1);
        end
        a_req = 1'b1; a_write = 1'b1; a_addr = 10'd5; a_wdata = 32'h99; a_wmask = 4'hF;
        @(posedge clk);
        #1;
        total++;
        if (a_rv0 !== 1'b0 || a_rv1 !== 1'b0) begin
            nbad++;
            $display("FAIL rst_hold: got v=%b/%b, want 0/0", a_rv0, a_rv1);
        end
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 10'd6, 32'h77, 4'hF, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        step(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, 1'b1, 1'b0, 10'd6, 32'h0, 4'h0);
        total++;
        if (a_rd0 !== 32'hA5A5A5A5 || b_rd0 !== 32'h77) begin
            nbad++;
            $display("FAIL rst_write: got %h/%h, want a5a5a5a5/00000077", a_rd0, b_rd0);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_mask();
        test_rdw();
        test_collision();
        test_out_of_range();
        test_random();
`ifdef PRIM_RAM_2P_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
